// File: rtl/packet_producer.sv
// packet_producer: emits a packet body of incrementing bytes on one AXI-Stream
// master, then a single size beat on a second master, and counts the packets
// whose size beat was accepted.
//
// state | meaning
// IDLE  | waiting for enable with a nonzero packet_size
// BODY  | presenting body beats 0..N-1
// SIZE  | presenting the latched packet size beat
module packet_producer #(
    parameter int DW = 512
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [15:0]     packet_size,
    output logic [DW-1:0]   axis_packetbody_tdata,
    output logic [DW/8-1:0] axis_packetbody_tkeep,
    output logic            axis_packetbody_tlast,
    output logic            axis_packetbody_tvalid,
    input  logic            axis_packetbody_tready,
    output logic [DW-1:0]   axis_packetsize_tdata,
    output logic [DW/8-1:0] axis_packetsize_tkeep,
    output logic            axis_packetsize_tlast,
    output logic            axis_packetsize_tvalid,
    input  logic            axis_packetsize_tready,
    output logic [31:0]     pkt_count
);

    localparam int BYTES = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        SIZE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       size_q, size_d;
    logic [15:0]       beat_q, beat_d;
    // bytes remaining in the packet, counted from the start of the current beat
    logic [15:0]       left_q, left_d;
    logic [DW-1:0]     body_data_q, body_data_d;
    logic [BYTES-1:0]  body_keep_q, body_keep_d;
    logic              body_last_q, body_last_d;
    logic              body_valid_q, body_valid_d;
    logic [DW-1:0]     size_data_q, size_data_d;
    logic [BYTES-1:0]  size_keep_q, size_keep_d;
    logic              size_last_q, size_last_d;
    logic              size_valid_q, size_valid_d;
    logic [31:0]       pkt_count_q, pkt_count_d;

    // Lane i of beat k carries (k*BYTES + i) mod 256; only the low 8 bits of
    // the beat offset matter, so the product is truncated.
    function automatic logic [DW-1:0] beat_data(input logic [15:0] beat);
        logic [7:0]    base;
        logic [DW-1:0] d;
        d    = '0;
        base = 8'(int'({16'd0, beat}) * BYTES);
        for (int i = 0; i < BYTES; i++) begin
            d[i*8 +: 8] = base + 8'(i);
        end
        return d;
    endfunction

    // A lane is kept while it lies inside the remaining byte count; non-final
    // beats and exact-multiple final beats therefore come out all ones.
    function automatic logic [BYTES-1:0] beat_keep(input logic [15:0] left);
        logic [BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < BYTES; i++) begin
            k[i] = (int'({16'd0, left}) > i);
        end
        return k;
    endfunction

    function automatic logic beat_is_last(input logic [15:0] left);
        return (int'({16'd0, left}) <= BYTES);
    endfunction

    // Next-state and next-output logic; every output is loaded one cycle ahead.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        beat_d       = beat_q;
        left_d       = left_q;
        body_data_d  = body_data_q;
        body_keep_d  = body_keep_q;
        body_last_d  = body_last_q;
        body_valid_d = body_valid_q;
        size_data_d  = size_data_q;
        size_keep_d  = size_keep_q;
        size_last_d  = size_last_q;
        size_valid_d = size_valid_q;
        pkt_count_d  = pkt_count_q;

        case (state_q)
            IDLE: begin
                if (enable && (packet_size != 16'd0)) begin
                    size_d       = packet_size;
                    beat_d       = 16'd0;
                    left_d       = packet_size;
                    body_data_d  = beat_data(16'd0);
                    body_keep_d  = beat_keep(packet_size);
                    body_last_d  = beat_is_last(packet_size);
                    body_valid_d = 1'b1;
                    state_d      = BODY;
                end
            end
            BODY: begin
                if (body_valid_q && axis_packetbody_tready) begin
                    if (body_last_q) begin
                        body_valid_d = 1'b0;
                        body_last_d  = 1'b0;
                        size_data_d  = DW'(size_q);
                        size_keep_d  = '1;
                        size_last_d  = 1'b1;
                        size_valid_d = 1'b1;
                        state_d      = SIZE;
                    end else begin
                        beat_d      = beat_q + 16'd1;
                        left_d      = left_q - 16'(BYTES);
                        body_data_d = beat_data(beat_q + 16'd1);
                        body_keep_d = beat_keep(left_q - 16'(BYTES));
                        body_last_d = beat_is_last(left_q - 16'(BYTES));
                    end
                end
            end
            SIZE: begin
                if (size_valid_q && axis_packetsize_tready) begin
                    size_valid_d = 1'b0;
                    size_last_d  = 1'b0;
                    pkt_count_d  = pkt_count_q + 32'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= '0;
            beat_q       <= '0;
            left_q       <= '0;
            body_data_q  <= '0;
            body_keep_q  <= '0;
            body_last_q  <= 1'b0;
            body_valid_q <= 1'b0;
            size_data_q  <= '0;
            size_keep_q  <= '0;
            size_last_q  <= 1'b0;
            size_valid_q <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            beat_q       <= beat_d;
            left_q       <= left_d;
            body_data_q  <= body_data_d;
            body_keep_q  <= body_keep_d;
            body_last_q  <= body_last_d;
            body_valid_q <= body_valid_d;
            size_data_q  <= size_data_d;
            size_keep_q  <= size_keep_d;
            size_last_q  <= size_last_d;
            size_valid_q <= size_valid_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign axis_packetbody_tdata  = body_data_q;
    assign axis_packetbody_tkeep  = body_keep_q;
    assign axis_packetbody_tlast  = body_last_q;
    assign axis_packetbody_tvalid = body_valid_q;
    assign axis_packetsize_tdata  = size_data_q;
    assign axis_packetsize_tkeep  = size_keep_q;
    assign axis_packetsize_tlast  = size_last_q;
    assign axis_packetsize_tvalid = size_valid_q;
    assign pkt_count              = pkt_count_q;

endmodule

// File: tb/tb_packet_producer.sv
// Testbench for packet_producer (DW=512): directed packets plus randomized
// sizes and ready patterns, checked against a byte-level packet model.
module tb_packet_producer;

    localparam int DW = 512;
    localparam int BYTES = DW / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [15:0]      packet_size;
    logic [DW-1:0]    body_tdata;
    logic [BYTES-1:0] body_tkeep;
    logic             body_tlast;
    logic             body_tvalid;
    logic             body_tready;
    logic [DW-1:0]    size_tdata;
    logic [BYTES-1:0] size_tkeep;
    logic             size_tlast;
    logic             size_tvalid;
    logic             size_tready;
    logic [31:0]      pkt_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    packet_producer #(.DW(DW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .enable                 (enable),
        .packet_size            (packet_size),
        .axis_packetbody_tdata  (body_tdata),
        .axis_packetbody_tkeep  (body_tkeep),
        .axis_packetbody_tlast  (body_tlast),
        .axis_packetbody_tvalid (body_tvalid),
        .axis_packetbody_tready (body_tready),
        .axis_packetsize_tdata  (size_tdata),
        .axis_packetsize_tkeep  (size_tkeep),
        .axis_packetsize_tlast  (size_tlast),
        .axis_packetsize_tvalid (size_tvalid),
        .axis_packetsize_tready (size_tready),
        .pkt_count              (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte at absolute offset b of any packet is b mod 256.
    function automatic logic [DW-1:0] model_data(input int k);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < BYTES; i++) d[i*8 +: 8] = 8'((k * BYTES + i) % 256);
        return d;
    endfunction

    // Reference: only bytes below the packet length are kept.
    function automatic logic [BYTES-1:0] model_keep(input int size, input int k);
        logic [BYTES-1:0] kp;
        for (int i = 0; i < BYTES; i++) kp[i] = ((k * BYTES + i) < size);
        return kp;
    endfunction

    task automatic check_idle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            chk({tag, "_body_tvalid"}, DW'(body_tvalid), DW'(0));
            chk({tag, "_size_tvalid"}, DW'(size_tvalid), DW'(0));
            packet_size = 16'($urandom_range(0, 65535));
            body_tready = 1'($urandom_range(0, 1));
            size_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    // Called and returns at a negedge with the DUT in IDLE.
    task automatic send_packet(input int size, input bit rand_body, input int size_stall, input int hold);
        int n, k, cyc;
        bit first, stalled, tr;
        logic [DW-1:0] p_data;
        logic [BYTES-1:0] p_keep;
        logic p_last;
        n = (size + BYTES - 1) / BYTES;
        k = 0; cyc = 0; first = 1; stalled = 0;
        p_data = '0; p_keep = '0; p_last = 0;
        enable = 1'b1;
        packet_size = 16'(size);
        @(negedge clk);
        while (k < n && cyc < 2000) begin
            if (k >= hold) enable = 1'b0;
            else packet_size = 16'($urandom_range(1, 65535));
            if (first) chk("body_tvalid_after_latch", DW'(body_tvalid), DW'(1));
            first = 0;
            chk("size_tvalid_during_body", DW'(size_tvalid), DW'(0));
            if (stalled) begin
                chk("stall_tvalid", DW'(body_tvalid), DW'(1));
                chk("stall_tdata", body_tdata, p_data);
                chk("stall_tkeep", DW'(body_tkeep), DW'(p_keep));
                chk("stall_tlast", DW'(body_tlast), DW'(p_last));
            end
            tr = rand_body ? 1'($urandom_range(0, 1)) : 1'b1;
            body_tready = tr;
            size_tready = 1'($urandom_range(0, 1));
            if (body_tvalid && tr) begin
                chk($sformatf("s%0d_b%0d_tdata", size, k), body_tdata, model_data(k));
                chk($sformatf("s%0d_b%0d_tkeep", size, k), DW'(body_tkeep), DW'(model_keep(size, k)));
                chk($sformatf("s%0d_b%0d_tlast", size, k), DW'(body_tlast), DW'(k == n - 1));
                k++;
                stalled = 0;
            end else begin
                stalled = body_tvalid;
            end
            p_data = body_tdata; p_keep = body_tkeep; p_last = body_tlast;
            @(negedge clk);
            cyc++;
        end
        enable = 1'b0;
        chk("body_beat_count", DW'(k), DW'(n));
        chk("body_tvalid_after_last", DW'(body_tvalid), DW'(0));
        size_tready = 1'b0;
        for (int s = 0; s <= size_stall; s++) begin
            body_tready = 1'($urandom_range(0, 1));
            chk("size_tvalid", DW'(size_tvalid), DW'(1));
            chk("size_tdata", size_tdata, DW'(size));
            chk("size_tkeep", DW'(size_tkeep), {DW{1'b1}} >> (DW - BYTES));
            chk("size_tlast", DW'(size_tlast), DW'(1));
            chk("pkt_count_before_accept", DW'(pkt_count), DW'(exp_count));
            if (s == size_stall) size_tready = 1'b1;
            @(negedge clk);
        end
        exp_count++;
        size_tready = 1'b0;
        chk("size_tvalid_after_accept", DW'(size_tvalid), DW'(0));
        chk("pkt_count_after_accept", DW'(pkt_count), DW'(exp_count));
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        packet_size = 16'd64;
        body_tready = 1'b1;
        size_tready = 1'b1;
        repeat (3) @(negedge clk);
        // reset dominates an asserted enable
        chk("rst_body_tvalid", DW'(body_tvalid), DW'(0));
        chk("rst_body_tdata", body_tdata, DW'(0));
        chk("rst_body_tkeep", DW'(body_tkeep), DW'(0));
        chk("rst_body_tlast", DW'(body_tlast), DW'(0));
        chk("rst_size_tvalid", DW'(size_tvalid), DW'(0));
        chk("rst_size_tdata", size_tdata, DW'(0));
        chk("rst_pkt_count", DW'(pkt_count), DW'(0));
        rst = 1'b0;
        enable = 1'b0;

        // zero-length requests never start a packet
        enable = 1'b1;
        packet_size = 16'd0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("zero_size_body_tvalid", DW'(body_tvalid), DW'(0));
            chk("zero_size_size_tvalid", DW'(size_tvalid), DW'(0));
            @(negedge clk);
        end
        enable = 1'b0;

        send_packet(64, 0, 0, 0);
        send_packet(100, 0, 0, 0);
        send_packet(300, 0, 0, 0);
        send_packet(200, 1, 5, 0);

        // reset while beat 2 of a 300-byte packet is on the bus
        enable = 1'b1;
        packet_size = 16'd300;
        body_tready = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_beat2_tdata", body_tdata, model_data(2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        chk("abort_body_tvalid", DW'(body_tvalid), DW'(0));
        chk("abort_size_tvalid", DW'(size_tvalid), DW'(0));
        chk("abort_pkt_count", DW'(pkt_count), DW'(0));
        send_packet(300, 0, 0, 0);

        // enable held through beat 0 only; packet completes then stays idle
        send_packet(128, 0, 0, 1);
        check_idle("post_disable", 8);

        for (int p = 0; p < 20; p++) begin
            send_packet($urandom_range(1, 400), 1, $urandom_range(0, 3), $urandom_range(0, 2));
        end
        check_idle("final", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_producer.md
PACKET_PRODUCER -- requirements
Module: packet_producer

Interface
REQ-001 SHALL have parameter DW, default 512, body/size stream data width in bits (multiple of 16, >=16); DW/8 bytes per beat.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  permits start of new packets.
REQ-005 SHALL have port packet_size  input  16  packet length in bytes, sampled at packet start.
REQ-006 SHALL have ports axis_packetbody_tdata/tkeep/tlast/tvalid  output  DW/DW/8/1/1  body AXI-Stream master.
REQ-007 SHALL have port axis_packetbody_tready  input  1  body stream ready.
REQ-008 SHALL have ports axis_packetsize_tdata/tkeep/tlast/tvalid  output  DW/DW/8/1/1  size AXI-Stream master.
REQ-009 SHALL have port axis_packetsize_tready  input  1  size stream ready.
REQ-010 SHALL have port pkt_count  output  32  number of completed packets (size beat accepted).

Function
REQ-011 SHALL implement FSM states IDLE, BODY, SIZE; all outputs registered.
REQ-012 IDLE: at an edge with enable=1 and packet_size!=0, SHALL latch packet_size, clear beat index, go to BODY; body tvalid=1 from the next cycle.
REQ-013 IDLE with packet_size=0 SHALL remain IDLE and emit nothing.
REQ-014 Beat count SHALL be ceil(size/(DW/8)); body beats indexed k=0..N-1.
REQ-015 Byte lane i of beat k SHALL equal (k*DW/8 + i) mod 256, including lanes with tkeep=0.
REQ-016 tkeep SHALL be all ones except on beat N-1, where the low (size mod DW/8) bits are set (all ones if remainder 0).
REQ-017 tlast SHALL be 1 only on beat N-1.
REQ-018 A beat transfers when tvalid&&tready; with tready held 1, SHALL sustain one beat per cycle.
REQ-019 While tvalid=1 and tready=0, tdata/tkeep/tlast SHALL hold stable and tvalid SHALL stay 1.
REQ-020 Handshake on beat N-1 SHALL deassert body tvalid next cycle and enter SIZE.
REQ-021 SIZE: size tvalid=1, tdata = latched size zero-extended to DW, tkeep all ones, tlast=1; held stable until accepted.
REQ-022 Size handshake SHALL increment pkt_count (wrapping mod 2^32), deassert size tvalid, return to IDLE; at least one IDLE cycle between packets.
REQ-023 Body and size tvalid SHALL never be 1 in the same cycle.
REQ-024 enable or packet_size changes after latch SHALL not affect the packet in flight; deasserting enable mid-packet completes body and size beats, then idles.
REQ-025 tready asserted while tvalid=0 SHALL have no effect.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE; both tvalid=0, tlast=0, tdata=0, tkeep=0, pkt_count=0, beat index=0, on the next cycle.
REQ-027 Reset mid-packet SHALL abandon the packet; after release the next packet restarts from byte 0 with no size beat for the aborted one.
REQ-028 rst SHALL take priority over enable and all handshakes in the same cycle.

Verification (DW=512)
REQ-029 size=64, both treadys=1 -> 1 body beat, bytes 0..63, tkeep all ones, tlast=1; then size beat tdata=64; pkt_count=1.
REQ-030 size=100 -> 2 beats; beat1 bytes 64..99 in lanes 0..35, tkeep=0x0000000FFFFFFFFF, tlast=1; size beat tdata=100.
REQ-031 size=300 -> 5 beats; beat4 lane0=0x00 (256 mod 256), tkeep low 44 bits set; size beat tdata=300.
REQ-032 size=200, body tready pseudo-random 50% -> 4 beats, data stable during stalls, no loss/duplication; size tready held 0 for 5 cycles -> size beat held stable, pkt_count unchanged until accepted.
REQ-033 rst asserted during beat 2 of a size=300 packet -> next cycle both tvalid=0, pkt_count=0; after release new packet starts with byte 0.
REQ-034 enable deasserted after beat 0 of size=128 -> beat 1 and size beat (128) still emitted, then IDLE with no further packets.
